// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC multi-cycle execution sequencer.
package npc_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StIwait,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StErr
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/npc_seq_watchdog.sv
// Wait-cycle counter: cleared on entry to a memory wait, flags expiry at TIMEOUT-1 cycles.
module npc_seq_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturate at the limit so a stalled wait keeps reporting expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == Limit);

endmodule

// File: rtl/npc_exec_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC and steps fetch/decode/exec/mem/write-back,
// with a response watchdog and terminal halt/error states.
module npc_exec_sequencer
  import npc_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned          CNT_WIDTH = 32,
  parameter int unsigned          TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ifu_req_valid,
  input  logic                 ifu_req_ready,
  output logic [PC_WIDTH-1:0]  ifu_req_addr,
  input  logic                 ifu_rsp_valid,
  output logic                 ifu_rsp_ready,
  input  logic [31:0]          ifu_rsp_inst,
  output logic [31:0]          inst,
  input  logic                 idu_is_mem,
  input  logic                 idu_is_ebreak,
  input  logic [PC_WIDTH-1:0]  exu_next_pc,
  output logic                 exu_en,
  output logic                 lsu_req_valid,
  input  logic                 lsu_req_ready,
  input  logic                 lsu_rsp_valid,
  output logic                 rf_wen_gate,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [CNT_WIDTH-1:0] retired,
  output logic                 halted,
  output logic                 error
);

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    npc_q, npc_d;
  logic [31:0]            inst_q, inst_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;
  logic                   lsu_acc_q, lsu_acc_d;
  logic                   wd_clr, wd_en, wd_expired;

  npc_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      npc_q     <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      lsu_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      lsu_acc_q <= lsu_acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    lsu_acc_d = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    case (state_q)
      StFetch: begin
        if (ifu_req_ready) begin
          state_d = StIwait;
          wd_clr  = 1'b1;
        end
      end
      StIwait: begin
        wd_en = 1'b1;
        // A response in the expiry cycle still wins over the timeout.
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_inst;
          state_d = StDecode;
        end else if (wd_expired) begin
          state_d = StErr;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        npc_d = exu_next_pc;
        if (idu_is_ebreak) begin
          state_d = StHalt;
        end else if (exu_next_pc[1:0] != 2'b00) begin
          state_d = StErr;
        end else if (idu_is_mem) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (!lsu_acc_q) begin
          // Responses in the acceptance cycle are not taken.
          lsu_acc_d = lsu_req_ready;
          wd_clr    = lsu_req_ready;
        end else begin
          lsu_acc_d = 1'b1;
          wd_en     = 1'b1;
          if (lsu_rsp_valid) begin
            lsu_acc_d = 1'b0;
            state_d   = StWb;
          end else if (wd_expired) begin
            lsu_acc_d = 1'b0;
            state_d   = StErr;
          end
        end
      end
      StWb: begin
        pc_d      = npc_q;
        retired_d = retired_q + 1'b1;
        state_d   = StFetch;
      end
      StHalt, StErr: ;
      default: state_d = StErr;
    endcase
  end

  // Reset forces FETCH, so the fetch request is qualified by rst to stay low during reset.
  always_comb begin
    ifu_req_valid = rst && (state_q == StFetch);
    ifu_rsp_ready = (state_q == StIwait);
    exu_en        = (state_q == StExec);
    lsu_req_valid = (state_q == StMem) && !lsu_acc_q;
    rf_wen_gate   = (state_q == StWb);
    halted        = (state_q == StHalt);
    error         = (state_q == StErr);
  end

  assign ifu_req_addr = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_npc_exec_sequencer.sv
// Directed table-driven bench for npc_exec_sequencer with a reactive IFU/LSU responder.
module tb_npc_exec_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_req_addr, ifu_rsp_inst, inst, exu_next_pc, pc, retired;
  logic        idu_is_mem, idu_is_ebreak, exu_en, lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic        rf_wen_gate, halted, error;

  int checks = 0;
  int errors = 0;
  logic [31:0] start_pc;

  typedef struct {
    string       name;
    logic [31:0] inst;
    bit          is_mem;
    bit          is_ebreak;
    logic [31:0] npc;
    int          ifu_rdy_dly;
    int          ifu_rsp_dly;
    int          lsu_rdy_dly;
    int          lsu_rsp_dly;
    int          exp_exec;
    int          exp_wb;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    bit          exp_halt;
    bit          exp_err;
  } vec_t;

  vec_t vecs[12];

  npc_exec_sequencer #(
    .PC_WIDTH  (32),
    .RESET_PC  (RST_PC),
    .CNT_WIDTH (32),
    .TIMEOUT   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .inst          (inst),
    .idu_is_mem    (idu_is_mem),
    .idu_is_ebreak (idu_is_ebreak),
    .exu_next_pc   (exu_next_pc),
    .exu_en        (exu_en),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .rf_wen_gate   (rf_wen_gate),
    .pc            (pc),
    .retired       (retired),
    .halted        (halted),
    .error         (error)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [31:0] i, bit m, bit e, logic [31:0] npc,
                              int ir, int is, int lr, int ls, int ec, int wc,
                              logic [31:0] epc, logic [31:0] ert, bit h, bit er);
    vec_t v;
    v.name = n; v.inst = i; v.is_mem = m; v.is_ebreak = e; v.npc = npc;
    v.ifu_rdy_dly = ir; v.ifu_rsp_dly = is; v.lsu_rdy_dly = lr; v.lsu_rsp_dly = ls;
    v.exp_exec = ec; v.exp_wb = wc; v.exp_pc = epc; v.exp_ret = ert;
    v.exp_halt = h; v.exp_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_inst = '0;
    idu_is_mem = 1'b0; idu_is_ebreak = 1'b0; exu_next_pc = '0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
  endtask

  // Holds reset over two edges, checks reset values, releases; returns in the first FETCH cycle.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.outs", {ifu_req_valid, ifu_rsp_ready, exu_en, lsu_req_valid, rf_wen_gate,
                       halted, error}, 7'b0);
    chk("reset.pc", pc, RST_PC);
    chk("reset.inst", inst, 32'h0);
    chk("reset.retired", retired, 32'h0);
    rst = 1'b1;
    #1;
    start_pc = RST_PC;
  endtask

  task automatic run_vec(input vec_t v);
    int c = 1, ifu_wait = 0, lsu_wait = 0, f_acc = 0, l_acc = 0, exec_c = 0, wb_c = 0;
    bit f_done = 0, l_done = 0, l_started = 0, overlap = 0, unstable = 0, ended = 0;
    idu_is_mem = v.is_mem; idu_is_ebreak = v.is_ebreak; exu_next_pc = v.npc;
    ifu_rsp_inst = v.inst;
    while (c < 60) begin
      if (halted || error || (wb_c != 0 && ifu_req_valid)) begin
        ended = 1;
        break;
      end
      if (exu_en && rf_wen_gate) overlap = 1;
      if (exu_en) exec_c = c;
      if (rf_wen_gate) wb_c = c;
      if (f_acc == 0) begin
        if (!ifu_req_valid || ifu_req_addr !== start_pc) unstable = 1;
        ifu_req_ready = (ifu_wait >= v.ifu_rdy_dly);
        if (ifu_req_ready && ifu_req_valid) f_acc = c;
        else ifu_wait++;
      end else begin
        ifu_req_ready = 1'b0;
      end
      ifu_rsp_valid = (f_acc != 0) && !f_done && (c >= f_acc + 1 + v.ifu_rsp_dly);
      if (ifu_rsp_valid && ifu_rsp_ready) f_done = 1;
      if (lsu_req_valid) l_started = 1;
      if (l_started && l_acc == 0 && !lsu_req_valid) unstable = 1;
      if (l_acc == 0 && lsu_req_valid) begin
        lsu_req_ready = (lsu_wait >= v.lsu_rdy_dly);
        if (lsu_req_ready) l_acc = c;
        else lsu_wait++;
      end else begin
        lsu_req_ready = 1'b0;
      end
      lsu_rsp_valid = (l_acc != 0) && !l_done && (c >= l_acc + 1 + v.lsu_rsp_dly);
      if (lsu_rsp_valid) l_done = 1;
      step();
      c++;
    end
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    chk($sformatf("%s.ended", v.name), 64'(ended), 64'd1);
    chk($sformatf("%s.exu_en_cycle", v.name), 64'(exec_c), 64'(v.exp_exec));
    chk($sformatf("%s.wen_cycle", v.name), 64'(wb_c), 64'(v.exp_wb));
    chk($sformatf("%s.pc", v.name), pc, v.exp_pc);
    chk($sformatf("%s.retired", v.name), retired, v.exp_ret);
    chk($sformatf("%s.halted", v.name), 64'(halted), 64'(v.exp_halt));
    chk($sformatf("%s.error", v.name), 64'(error), 64'(v.exp_err));
    chk($sformatf("%s.strobe_overlap", v.name), 64'(overlap), 64'd0);
    chk($sformatf("%s.req_stable", v.name), 64'(unstable), 64'd0);
    if (v.exp_exec != 0) chk($sformatf("%s.inst", v.name), inst, v.inst);
    start_pc = v.exp_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bit bad;
    //            name            inst          m  e  npc           ir is  lr ls  ec wc  pc            ret h  er
    vecs[0]  = mk("addi",         32'h00100093, 0, 0, 32'h80000004, 0, 0,   0, 0,   4, 5,  32'h80000004, 1, 0, 0);
    vecs[1]  = mk("ifu_stall",    32'h00208113, 0, 0, 32'h80000008, 3, 0,   0, 0,   7, 8,  32'h80000008, 2, 0, 0);
    vecs[2]  = mk("jal",          32'h0f80006f, 0, 0, 32'h80000100, 0, 2,   0, 0,   6, 7,  32'h80000100, 3, 0, 0);
    vecs[3]  = mk("load",         32'h0000a183, 1, 0, 32'h80000104, 0, 0,   0, 1,   4, 8,  32'h80000104, 4, 0, 0);
    vecs[4]  = mk("store",        32'h0030a023, 1, 0, 32'h80000108, 0, 0,   0, 0,   4, 7,  32'h80000108, 5, 0, 0);
    vecs[5]  = mk("store_stall",  32'h0030a223, 1, 0, 32'h8000010c, 0, 0,   2, 0,   4, 9,  32'h8000010c, 6, 0, 0);
    vecs[6]  = mk("ifu_at_limit", 32'h00000013, 0, 0, 32'h80000110, 0, 3,   0, 0,   7, 8,  32'h80000110, 7, 0, 0);
    vecs[7]  = mk("lsu_at_limit", 32'h0040a203, 1, 0, 32'h80000114, 0, 0,   0, 3,   4, 10, 32'h80000114, 8, 0, 0);
    vecs[8]  = mk("ifu_timeout",  32'h00000013, 0, 0, 32'h80000118, 0, 100, 0, 0,   0, 0,  32'h80000114, 8, 0, 1);
    vecs[9]  = mk("misaligned",   32'h0060006f, 0, 0, 32'h80000006, 0, 0,   0, 0,   4, 0,  32'h80000000, 0, 0, 1);
    vecs[10] = mk("lsu_timeout",  32'h0000a283, 1, 0, 32'h80000004, 0, 0,   0, 100, 4, 0,  32'h80000000, 0, 0, 1);
    vecs[11] = mk("ebreak",       32'h00100073, 0, 1, 32'h80000004, 0, 0,   0, 0,   4, 0,  32'h80000000, 0, 1, 0);

    do_reset();
    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (vecs[i].exp_halt) begin
        // Halted core must stay silent even with the fetch port offering ready.
        bad = 0;
        ifu_req_ready = 1'b1;
        repeat (4) begin
          if (ifu_req_valid || lsu_req_valid || exu_en || rf_wen_gate || !halted ||
              pc !== RST_PC) bad = 1;
          step();
        end
        ifu_req_ready = 1'b0;
        chk("ebreak.hold", 64'(bad), 64'd0);
      end
      if (vecs[i].exp_halt || vecs[i].exp_err) do_reset();
    end

    // Asynchronous reset while a memory request is outstanding.
    run_vec(vecs[0]);
    ifu_req_ready = 1'b1; ifu_rsp_inst = 32'h0000a303;
    idu_is_mem = 1'b1; idu_is_ebreak = 1'b0; exu_next_pc = 32'h80000008;
    step();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1;
    step();
    ifu_rsp_valid = 1'b0;
    step();
    step();
    chk("midmem.lsu_req_valid", 64'(lsu_req_valid), 64'd1);
    chk("midmem.pc_before", pc, 32'h80000004);
    #2;
    rst = 1'b0;
    #1;
    chk("midmem.lsu_cleared", 64'(lsu_req_valid), 64'd0);
    chk("midmem.ifu_cleared", 64'(ifu_req_valid), 64'd0);
    chk("midmem.pc_reset", pc, RST_PC);
    chk("midmem.inst_reset", inst, 32'h0);
    chk("midmem.retired_reset", retired, 32'h0);
    clear_inputs();
    step();
    rst = 1'b1;
    #1;
    start_pc = RST_PC;
    chk("restart.ifu_req_valid", 64'(ifu_req_valid), 64'd1);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npc_exec_sequencer.md
# npc_exec_sequencer

Multi-cycle sequencer for the NPC core: owns the PC and steps each instruction through fetch, decode, execute, optional memory access and register write-back. It drives the instruction-fetch and load/store handshakes and pulses the EXU enable and register-file write gate. A watchdog traps hung memory responses, and a halt state is entered on `ebreak`. It sits between the IFU/LSU memory ports and the IDU/EXU datapath.

## Interface
- `PC_WIDTH`, 32, PC and instruction-address width
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset
- `CNT_WIDTH`, 32, retired-instruction counter width
- `TIMEOUT`, 1024, maximum wait cycles for any memory response (≥2)

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge
- `rst` in 1: asynchronous, active-low reset
- `ifu_req_valid` out 1: fetch request
- `ifu_req_ready` in 1: fetch request accepted
- `ifu_req_addr` out PC_WIDTH: fetch address; always equals `pc`
- `ifu_rsp_valid` in 1: fetched instruction valid
- `ifu_rsp_ready` out 1: sequencer accepts the instruction
- `ifu_rsp_inst` in 32: fetched instruction
- `inst` out 32: latched instruction presented to the IDU
- `idu_is_mem` in 1: decoded instruction is a load or store
- `idu_is_ebreak` in 1: decoded instruction is `ebreak`
- `exu_next_pc` in PC_WIDTH: next PC from the EXU (pc+4 or target)
- `exu_en` out 1: one-cycle execute strobe
- `lsu_req_valid` out 1: memory request
- `lsu_req_ready` in 1: memory request accepted
- `lsu_rsp_valid` in 1: memory response (load data or store ack)
- `rf_wen_gate` out 1: qualifies the EXU write enable; register file writes only when this is 1
- `pc` out PC_WIDTH: current PC
- `retired` out CNT_WIDTH: count of committed instructions
- `halted` out 1: sticky; `ebreak` reached
- `error` out 1: sticky; timeout or misaligned next PC

## Operation
States and transitions:
- FETCH → IWAIT when `ifu_req_valid && ifu_req_ready`.
- IWAIT → DECODE on `ifu_rsp_valid`; `inst` is latched on that edge.
- DECODE → EXEC, unconditionally after 1 cycle.
- EXEC (`exu_en`=1 for exactly this cycle):
  - to HALT if `idu_is_ebreak`;
  - else to ERR if `exu_next_pc[1:0]` ≠ 0;
  - else to MEM if `idu_is_mem`;
  - else to WB.
  - `exu_next_pc` is captured into the internal `npc` register on this edge.
- MEM: raises `lsu_req_valid`. After `lsu_req_ready`, it waits for `lsu_rsp_valid`, then goes to WB. An internal flag tracks whether the request has been accepted.
- WB: `rf_wen_gate`=1 for 1 cycle; `pc` ← `npc`; `retired` += 1, wrapping modulo 2^CNT_WIDTH; then → FETCH.
- HALT and ERR are terminal until reset. No request outputs are asserted in either state, and `pc` is frozen at the offending instruction.

Handshake rules:
- Once asserted, `ifu_req_valid` and `lsu_req_valid` stay high with a stable address until ready. They are never retracted.
- `ifu_rsp_ready` = 1 only in IWAIT. A response arriving in any other state is ignored.
- A response arriving in the same cycle the request is accepted is not taken. The earliest accepted response is one cycle after acceptance.

Watchdog:
- Counts cycles spent in IWAIT, and in MEM after request acceptance. It clears on entry to either wait.
- If the count reaches TIMEOUT−1 without the matching response, next state is ERR.
- A response in that same cycle wins: no error.

## Timing
- Reset values: `pc`=RESET_PC, state=FETCH, `inst`=0, `retired`=0, all valid/ready/strobe outputs 0, `halted`=0, `error`=0.
- First `ifu_req_valid`=1 is in the first cycle after `rst` deasserts.
- Zero-wait memories:
  - non-memory instruction: 5 cycles (FETCH, IWAIT, DECODE, EXEC, WB);
  - memory instruction: 7 cycles (adds MEM request and MEM response).
- `exu_en` and `rf_wen_gate` are registered state decodes and are never high in the same cycle.
- Reset asserted mid-instruction immediately clears all outputs. An in-flight request is abandoned, and the memories must tolerate this.

## Structure
- Shared package `npc_pkg`: state enum (FETCH, IWAIT, DECODE, EXEC, MEM, WB, HALT, ERR) and the `RESET_PC` default constant.
- One sub-module, `npc_seq_watchdog`: counter with clear/enable inputs and a `expired` output, parameterised by TIMEOUT.

## Test plan
- Zero-wait fetch of `addi`, `exu_next_pc`=0x8000_0004 → `exu_en` at cycle 4, `rf_wen_gate` at cycle 5, `pc`=0x8000_0004, `retired`=1.
- `ifu_req_ready` withheld 3 cycles → `ifu_req_valid` and `ifu_req_addr`=0x8000_0000 held stable; completion at cycle 8.
- Load with `lsu_rsp_valid` 2 cycles after accept → WB one cycle later; `retired` increments once.
- `ebreak` → `halted`=1 after EXEC; `pc` frozen; no further `ifu_req_valid`.
- `ifu_rsp_valid` never returns with TIMEOUT=4 → `error`=1 four cycles into IWAIT. Response on exactly the fourth cycle → no error.
- `exu_next_pc`=0x8000_0006 → `error`=1, `rf_wen_gate` never asserted. Async reset mid-MEM → outputs cleared immediately, restart at 0x8000_0000.
